// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester arbiter in front of a single memory port.
//
// Requester 0 (dcache) and requester 1 (instruction refill / DMA) each
// present rd/wr controls, address and write data, and hold them until
// their ready pulse. The winner's request is latched on grant and replayed
// to memory from the latched copy, so requester inputs may change freely
// while BUSY. Each transaction walks IDLE -> BUSY -> DONE -> IDLE, giving
// at least one IDLE cycle between grants.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rN_rd_ctrl, rN_wr_ctrl   requester controls (3'b000 = none)
//   rN_addr, rN_din          requester address / write data
//   rN_dout, rN_ready        read data (held until next completion) and
//                            one-cycle completion pulse
//   mem_rd_ctrl/mem_wr_ctrl  downstream controls, nonzero only in BUSY
//   mem_addr, mem_din        downstream address / write data
//   mem_dout, mem_ready      downstream read data and completion pulse
//   grant                    one-hot current owner, 2'b00 when idle
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 has fixed priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  r0_rd_ctrl,
    input  logic [2:0]  r0_wr_ctrl,
    input  logic [63:0] r0_addr,
    input  logic [63:0] r0_din,
    output logic [63:0] r0_dout,
    output logic        r0_ready,
    input  logic [2:0]  r1_rd_ctrl,
    input  logic [2:0]  r1_wr_ctrl,
    input  logic [63:0] r1_addr,
    input  logic [63:0] r1_din,
    output logic [63:0] r1_dout,
    output logic        r1_ready,
    output logic [2:0]  mem_rd_ctrl,
    output logic [2:0]  mem_wr_ctrl,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_din,
    input  logic [63:0] mem_dout,
    input  logic        mem_ready,
    output logic [1:0]  grant
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  rd_q, rd_d, wr_q, wr_d;
    logic [63:0] addr_q, addr_d, din_q, din_d;
    logic [63:0] dout0_q, dout0_d, dout1_q, dout1_d;
    logic        rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic        req0, req1, pick1;

    assign req0 = (r0_rd_ctrl != 3'b000) || (r0_wr_ctrl != 3'b000);
    assign req1 = (r1_rd_ctrl != 3'b000) || (r1_wr_ctrl != 3'b000);

`ifdef MEM_ARB_RR_EN
    // last_q = 1 means port 1 owned the previous grant; on a tie the
    // other port wins. Resets to port 1 so port 0 takes the first tie.
    logic last_q, last_d;

    assign pick1 = req1 && (!req0 || !last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (req0 || req1))
            last_d = pick1;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`else
    assign pick1 = req1 && !req0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BUSY;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    rd_d    = pick1 ? r1_rd_ctrl : r0_rd_ctrl;
                    wr_d    = pick1 ? r1_wr_ctrl : r0_wr_ctrl;
                    addr_d  = pick1 ? r1_addr    : r0_addr;
                    din_d   = pick1 ? r1_din     : r0_din;
                end
            end
            BUSY: begin
                // Writes complete the same way; dout then takes whatever
                // memory drives.
                if (mem_ready) begin
                    state_d = DONE;
                    if (grant_q[1]) begin
                        dout1_d = mem_dout;
                        rdy1_d  = 1'b1;
                    end else begin
                        dout0_d = mem_dout;
                        rdy0_d  = 1'b1;
                    end
                end
            end
            default: begin
                // DONE (and any unreachable code) returns to IDLE.
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            rd_q    <= 3'b000;
            wr_q    <= 3'b000;
            addr_q  <= 64'd0;
            din_q   <= 64'd0;
            dout0_q <= 64'd0;
            dout1_q <= 64'd0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
        end
    end

    // Controls reach memory only while BUSY, so they drop in DONE.
    assign mem_rd_ctrl = (state_q == BUSY) ? rd_q : 3'b000;
    assign mem_wr_ctrl = (state_q == BUSY) ? wr_q : 3'b000;
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign grant       = grant_q;
    assign r0_dout     = dout0_q;
    assign r1_dout     = dout1_q;
    assign r0_ready    = rdy0_q;
    assign r1_ready    = rdy1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Expected completions (port, data) are
// queued when a transaction is granted and checked by a negedge monitor
// whenever a ready pulse appears.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  r0_rd_ctrl, r0_wr_ctrl, r1_rd_ctrl, r1_wr_ctrl;
    logic [63:0] r0_addr, r0_din, r1_addr, r1_din, r0_dout, r1_dout;
    logic        r0_ready, r1_ready;
    logic [2:0]  mem_rd_ctrl, mem_wr_ctrl;
    logic [63:0] mem_addr, mem_din, mem_dout;
    logic        mem_ready;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_rd_ctrl(r0_rd_ctrl), .r0_wr_ctrl(r0_wr_ctrl), .r0_addr(r0_addr),
        .r0_din(r0_din), .r0_dout(r0_dout), .r0_ready(r0_ready),
        .r1_rd_ctrl(r1_rd_ctrl), .r1_wr_ctrl(r1_wr_ctrl), .r1_addr(r1_addr),
        .r1_din(r1_din), .r1_dout(r1_dout), .r1_ready(r1_ready),
        .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .grant(grant)
    );

    typedef struct {
        logic        port;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the grant edge: memory answers lat cycles later.
    task automatic serve(input int lat, input logic [63:0] data);
        repeat (lat - 1) step();
        mem_ready = 1'b1;
        mem_dout  = data;
        step();
        mem_ready = 1'b0;
        mem_dout  = 64'h0BAD_0BAD_0BAD_0BAD;
    endtask

    always @(negedge clk) begin
        if (r0_ready || r1_ready) begin
            chk("ready_onehot", 64'(r0_ready & r1_ready), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ready", {62'd0, r1_ready, r0_ready}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ready_port", 64'(r1_ready), 64'(mon_e.port));
                chk("ready_dout", r1_ready ? r1_dout : r0_dout, mon_e.data);
            end
        end
    end

    initial begin
        logic        exp_p;
        logic [63:0] d;

        rst = 1'b1;
        r0_rd_ctrl = 3'b000; r0_wr_ctrl = 3'b000; r0_addr = 64'd0; r0_din = 64'd0;
        r1_rd_ctrl = 3'b000; r1_wr_ctrl = 3'b000; r1_addr = 64'd0; r1_din = 64'd0;
        mem_dout = 64'd0; mem_ready = 1'b0;
        step();
        step();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ready", {62'd0, r1_ready, r0_ready}, 64'd0);
        chk("rst_mem_ctrl", {58'd0, mem_rd_ctrl, mem_wr_ctrl}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_din", mem_din, 64'd0);
        chk("rst_r0_dout", r0_dout, 64'd0);
        chk("rst_r1_dout", r1_dout, 64'd0);
        rst = 1'b0;

        // Single read from port 0; address changes while BUSY.
        r0_rd_ctrl = 3'b011; r0_addr = 64'h80;
        step();
        chk("rd_grant", 64'(grant), 64'd1);
        chk("rd_mem_addr", mem_addr, 64'h80);
        chk("rd_mem_rd", 64'(mem_rd_ctrl), 64'd3);
        chk("rd_mem_wr", 64'(mem_wr_ctrl), 64'd0);
        r0_addr = 64'h100;
        sb.push_back('{1'b0, 64'hDEADBEEF});
        step();
        chk("busy_addr_hold", mem_addr, 64'h80);
        step();
        chk("busy_rd_hold", 64'(mem_rd_ctrl), 64'd3);
        mem_ready = 1'b1; mem_dout = 64'hDEADBEEF;
        step();
        mem_ready = 1'b0;
        chk("done_r0_ready", 64'(r0_ready), 64'd1);
        chk("done_r1_ready", 64'(r1_ready), 64'd0);
        chk("done_r0_dout", r0_dout, 64'hDEADBEEF);
        chk("done_mem_rd", 64'(mem_rd_ctrl), 64'd0);
        r0_rd_ctrl = 3'b000;
        step();
        chk("idle_r0_ready", 64'(r0_ready), 64'd0);
        chk("idle_grant", 64'(grant), 64'd0);

        // Stray mem_ready while IDLE.
        mem_ready = 1'b1; mem_dout = 64'h1234;
        step();
        mem_ready = 1'b0;
        chk("stray_grant", 64'(grant), 64'd0);
        chk("stray_mem_rd", 64'(mem_rd_ctrl), 64'd0);
        chk("stray_r0_dout", r0_dout, 64'hDEADBEEF);
        step();
        chk("stray_grant2", 64'(grant), 64'd0);

        // Write from port 1; port 0's dout must hold.
        r1_wr_ctrl = 3'b001; r1_addr = 64'h200; r1_din = 64'h55;
        step();
        chk("wr_grant", 64'(grant), 64'd2);
        chk("wr_mem_wr", 64'(mem_wr_ctrl), 64'd1);
        chk("wr_mem_rd", 64'(mem_rd_ctrl), 64'd0);
        chk("wr_mem_addr", mem_addr, 64'h200);
        chk("wr_mem_din", mem_din, 64'h55);
        sb.push_back('{1'b1, 64'hA5A5});
        serve(2, 64'hA5A5);
        chk("wr_done_mem_wr", 64'(mem_wr_ctrl), 64'd0);
        r1_wr_ctrl = 3'b000;
        step();
        chk("wr_r0_dout_hold", r0_dout, 64'hDEADBEEF);
        chk("wr_r1_dout", r1_dout, 64'hA5A5);

        // Reset mid-transaction: no ready, everything back to reset values.
        r0_rd_ctrl = 3'b001; r0_addr = 64'h300;
        step();
        chk("mid_grant", 64'(grant), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; r0_rd_ctrl = 3'b000;
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_mem_rd", 64'(mem_rd_ctrl), 64'd0);
        chk("mid_rst_ready", {62'd0, r1_ready, r0_ready}, 64'd0);
        chk("mid_rst_r0_dout", r0_dout, 64'd0);
        mem_ready = 1'b1; mem_dout = 64'h77;
        step();
        mem_ready = 1'b0;
        step();
        chk("mid_rst_idle", 64'(grant), 64'd0);

        // Both ports request every time; owner drops only after its ready.
        for (int i = 0; i < 4; i++) begin
            r0_rd_ctrl = 3'b010; r0_addr = 64'h400 + 64'(i);
            r1_rd_ctrl = 3'b100; r1_addr = 64'h800;
`ifdef MEM_ARB_RR_EN
            exp_p = (i % 2 == 1);
`else
            exp_p = 1'b0;
`endif
            d = 64'hC0DE_0000 + 64'(i);
            step();
            chk("arb_grant", 64'(grant), exp_p ? 64'd2 : 64'd1);
            chk("arb_mem_addr", mem_addr, exp_p ? 64'h800 : 64'h400 + 64'(i));
            sb.push_back('{exp_p, d});
            serve(1 + i % 3, d);
            if (exp_p) r1_rd_ctrl = 3'b000;
            else       r0_rd_ctrl = 3'b000;
            step();
            chk("arb_idle_gap", 64'(grant), 64'd0);
        end
        r0_rd_ctrl = 3'b000;
        r1_rd_ctrl = 3'b100; r1_addr = 64'h800;
        step();
        chk("lone_r1_grant", 64'(grant), 64'd2);
        sb.push_back('{1'b1, 64'hFACE});
        serve(3, 64'hFACE);
        r1_rd_ctrl = 3'b000;
        step();
        chk("lone_r1_dout", r1_dout, 64'hFACE);
        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
